arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 89 ++++++++
 1 files changed

// File: rtl/arb_mux.sv
// Registered N-to-1 arbiter/multiplexer: fixed-select or round-robin grant,
// one output word register with valid/ready back-pressure and a transfer counter.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [$clog2(NCH+1)-1:0]   i_sel,
    input  logic [NCH-1:0]             i_valid,
    input  logic [NCH*WIDTH-1:0]       i_data,
    output logic [NCH-1:0]             o_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(NCH)-1:0]     o_ch,
    input  logic                       i_ready,
    output logic                       o_sel_err,
    output logic [15:0]                o_count
);

    localparam int CHW = $clog2(NCH);

    logic           free;
    logic           grant_any;
    logic [CHW-1:0] grant_idx;
    logic [NCH-1:0] grant;
    logic           sel_bad;
    logic [CHW-1:0] rr_ptr;

    assign free    = ~o_valid | i_ready;
    // Reset forces o_ready low even though o_valid=0 makes the register look free.
    assign o_ready = grant & {NCH{free & ~i_rst}};

    // Grant depends only on requests, select and rr_ptr, never on o_ready.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel_bad   = 1'b0;
        grant     = '0;
        if (MODE == 0) begin
            sel_bad = int'(i_sel) > NCH;
            for (int k = 0; k < NCH; k++) begin
                if (int'(i_sel) == k + 1 && i_valid[k]) begin
                    grant_any = 1'b1;
                    grant_idx = CHW'(k);
                end
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest request wins.
            for (int off = NCH - 1; off >= 0; off--) begin
                int idx;
                idx = int'(rr_ptr) + off;
                if (idx >= NCH) idx = idx - NCH;
                if (i_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = CHW'(idx);
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_ch      <= '0;
            o_sel_err <= 1'b0;
            o_count   <= '0;
            rr_ptr    <= '0;
        end else begin
            o_sel_err <= sel_bad;
            if (free) begin
                o_valid <= grant_any;
                if (grant_any) begin
                    o_data  <= i_data[grant_idx*WIDTH +: WIDTH];
                    o_ch    <= grant_idx;
                    o_count <= o_count + 16'd1;
                    if (MODE == 1)
                        rr_ptr <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

endmodule
